acc_cpu_mc: RTL

- Parametrised multi-cycle successor of the single-cycle accumulator processor.
- Keeps the accumulator/PC/data-stack model and the 4-bit opcode format.
- Generalises data width, address width, stack base and stack depth.
- Adds a req/ready data-memory handshake with wait states, an explicit FETCH/EXEC/MEM state machine, HALT, and sticky fault detection (stack overflow, stack underflow, illegal opcode).
- Sits between the instruction ROM and the data RAM/arbiter at the top of the computer.

---
 rtl/acc_cpu_mc.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator CPU: FETCH/EXEC/MEM sequencing, req/ready data port,
// descending-free data stack at STACK_BASE, sticky HALT and FAULT terminal states.
module acc_cpu_mc #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] STACK_BASE  = 8'hC0,
  parameter int                STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W+3:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] acc_out,
  output logic              halted,
  output logic              fault
);

  // sp counts 0..STACK_DEPTH, so it needs one bit more than an address
  localparam int SP_W = ADDR_W + 1;

  localparam logic [3:0] OP_NOP  = 4'h0, OP_LOAD = 4'h1, OP_STORE = 4'h2,
                         OP_ADD  = 4'h3, OP_SUB  = 4'h4, OP_AND   = 4'h5,
                         OP_OR   = 4'h6, OP_XOR  = 4'h7, OP_JMP   = 4'h8,
                         OP_JNZ  = 4'h9, OP_JZ   = 4'hA, OP_PUSH  = 4'hB,
                         OP_POP  = 4'hC, OP_LDI  = 4'hD, OP_HALT  = 4'hE;

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_HALT, S_FAULT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W+3:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic                req_q, req_d, wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                halted_q, halted_d, fault_q, fault_d;

  logic [3:0]          opc;
  logic [ADDR_W-1:0]   operand, pc_inc, push_addr, pop_addr;
  logic                stk_full, stk_empty;

  assign opc       = ir_q[ADDR_W+3:ADDR_W];
  assign operand   = ir_q[ADDR_W-1:0];
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign push_addr = STACK_BASE + sp_q[ADDR_W-1:0];
  assign pop_addr  = STACK_BASE + sp_q[ADDR_W-1:0] - ADDR_W'(1);
  assign stk_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      acc_q    <= '0;
      sp_q     <= '0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      acc_q    <= acc_d;
      sp_q     <= sp_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    acc_d    = acc_q;
    sp_d     = sp_q;
    req_d    = req_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = instr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opc)
          OP_NOP: pc_d = pc_inc;
          OP_JMP: pc_d = operand;
          OP_JNZ: pc_d = (acc_q != '0) ? operand : pc_inc;
          OP_JZ:  pc_d = (acc_q == '0) ? operand : pc_inc;
          OP_LDI: begin
            acc_d = DATA_W'($signed(operand));
            pc_d  = pc_inc;
          end
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            req_d   = 1'b1;
            wr_d    = (opc == OP_STORE);
            addr_d  = operand;
            wdata_d = acc_q;
            state_d = S_MEM;
          end
          OP_PUSH: begin
            if (stk_full) begin
              fault_d = 1'b1;
              state_d = S_FAULT;
            end else begin
              req_d   = 1'b1;
              wr_d    = 1'b1;
              addr_d  = push_addr;
              wdata_d = acc_q;
              state_d = S_MEM;
            end
          end
          OP_POP: begin
            if (stk_empty) begin
              fault_d = 1'b1;
              state_d = S_FAULT;
            end else begin
              req_d   = 1'b1;
              wr_d    = 1'b0;
              addr_d  = pop_addr;
              wdata_d = acc_q;
              state_d = S_MEM;
            end
          end
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end
        endcase
      end
      S_MEM: begin
        // request fields stay put via the defaults until the slave is ready
        if (mem_ready) begin
          req_d   = 1'b0;
          pc_d    = pc_inc;
          state_d = S_FETCH;
          case (opc)
            OP_LOAD: acc_d = mem_rdata;
            OP_POP: begin
              acc_d = mem_rdata;
              sp_d  = sp_q - SP_W'(1);
            end
            OP_PUSH: sp_d = sp_q + SP_W'(1);
            OP_ADD:  acc_d = acc_q + mem_rdata;
            OP_SUB:  acc_d = acc_q - mem_rdata;
            OP_AND:  acc_d = acc_q & mem_rdata;
            OP_OR:   acc_d = acc_q | mem_rdata;
            OP_XOR:  acc_d = acc_q ^ mem_rdata;
            default: acc_d = acc_q;
          endcase
        end
      end
      default: state_d = state_q;
    endcase
  end

  assign instr_addr = pc_q;
  assign mem_req    = req_q;
  assign mem_wr     = wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign acc_out    = acc_q;
  assign halted     = halted_q;
  assign fault      = fault_q;

endmodule
